// File: rtl/mem_responder.sv
// Memory-side responder: 240-byte RAM plus switch/LED/HEX registers at 0xF0-0xF4,
// one response per accepted request after WAIT_CYCLES extra cycles.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  input  logic [9:0] sw_in,
  output logic [9:0] led_out,
  output logic [7:0] hex_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_write;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_rdata;
  logic       r_rsp_err;
  logic [9:0] r_sw_s1;
  logic [9:0] r_sw_s2;
  logic [9:0] r_led;
  logic [7:0] r_hex;
  logic [7:0] r_mem [0:239];

  logic       w_ram_hit;
  logic       w_ram_we;
  logic [7:0] w_rdata;
  logic       w_err;
  logic       w_led_lo_we;
  logic       w_led_hi_we;
  logic       w_hex_we;

  assign w_ram_hit = (r_addr < 8'hF0);
  assign w_ram_we  = (r_state == S_ACCESS) && r_write && w_ram_hit;

  always_comb begin
    w_rdata     = 8'h00;
    w_err       = 1'b0;
    w_led_lo_we = 1'b0;
    w_led_hi_we = 1'b0;
    w_hex_we    = 1'b0;
    unique case (1'b1)
      w_ram_hit: begin
        w_rdata = r_mem[r_addr];
      end
      (r_addr == 8'hF0): begin
        w_rdata = r_sw_s2[7:0];
        w_err   = r_write;
      end
      (r_addr == 8'hF1): begin
        w_rdata = {6'b0, r_sw_s2[9:8]};
        w_err   = r_write;
      end
      (r_addr == 8'hF2): begin
        w_rdata     = r_led[7:0];
        w_led_lo_we = r_write;
      end
      (r_addr == 8'hF3): begin
        w_rdata     = {6'b0, r_led[9:8]};
        w_led_hi_we = r_write;
      end
      (r_addr == 8'hF4): begin
        w_rdata  = r_hex;
        w_hex_we = r_write;
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // RAM is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge CLOCK_50) begin
    if (w_ram_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_sw_s1     <= 10'h000;
      r_sw_s2     <= 10'h000;
      r_led       <= 10'h000;
      r_hex       <= 8'h00;
    end else begin
      r_sw_s1 <= sw_in;
      r_sw_s2 <= r_sw_s1;
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= LP_WAIT;
            r_state <= (LP_WAIT == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_write ? 8'h00 : w_rdata;
          r_rsp_err   <= w_err;
          if (w_led_lo_we) begin
            r_led[7:0] <= r_wdata;
          end
          if (w_led_hi_we) begin
            r_led[9:8] <= r_wdata[1:0];
          end
          if (w_hex_we) begin
            r_hex <= r_wdata;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign led_out   = r_led;
  assign hex_out   = r_hex;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state,
// one with none; sel picks which one the shared request channel drives.
module tb_mem_responder;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [9:0] sw_in = 10'h000;

  logic       w_rdy0, w_rdy1, w_v0, w_v1, w_e0, w_e1;
  logic [7:0] w_rd0, w_rd1, w_hex0, w_hex1;
  logic [9:0] w_led0, w_led1;

  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata, hex_out;
  logic [9:0] led_out;

  assign req_ready = sel ? w_rdy0 : w_rdy1;
  assign rsp_valid = sel ? w_v0 : w_v1;
  assign rsp_rdata = sel ? w_rd0 : w_rd1;
  assign rsp_err   = sel ? w_e0 : w_e1;
  assign led_out   = sel ? w_led0 : w_led1;
  assign hex_out   = sel ? w_hex0 : w_hex1;

  mem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .req_valid(req_valid & ~sel),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(w_rdy1),
    .rsp_valid(w_v1),
    .rsp_rdata(w_rd1),
    .rsp_err  (w_e1),
    .sw_in    (sw_in),
    .led_out  (w_led1),
    .hex_out  (w_hex1)
  );

  mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .req_valid(req_valid & sel),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(w_rdy0),
    .rsp_valid(w_v0),
    .rsp_rdata(w_rd0),
    .rsp_err  (w_e0),
    .sw_in    (sw_in),
    .led_out  (w_led0),
    .hex_out  (w_hex0)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic prev_v = 1'b0;
  exp_t q[$];
  exp_t e;

  logic [7:0] m_ram [2][256];
  logic [9:0] m_led [2];
  logic [7:0] m_hex [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input bit s, input bit wr,
                                input logic [7:0] a, input logic [7:0] d,
                                output logic [7:0] rd, output logic er);
    rd = 8'h00;
    er = 1'b0;
    if (a < 8'hF0) begin
      if (wr) m_ram[s][a] = d;
      else    rd = m_ram[s][a];
    end else begin
      case (a)
        8'hF0: if (wr) er = 1'b1; else rd = sw_in[7:0];
        8'hF1: if (wr) er = 1'b1; else rd = {6'b0, sw_in[9:8]};
        8'hF2: if (wr) m_led[s][7:0] = d; else rd = m_led[s][7:0];
        8'hF3: if (wr) m_led[s][9:8] = d[1:0];
               else rd = {6'b0, m_led[s][9:8]};
        8'hF4: if (wr) m_hex[s] = d; else rd = m_hex[s];
        default: er = 1'b1;
      endcase
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input bit keep);
    logic [7:0] rd;
    logic       er;
    int         n;
    exp_t       x;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 50), 1);
    if (n >= 50) begin
      req_valid = 1'b0;
      return;
    end
    model(sel, wr, a, d, rd, er);
    x.rd  = rd;
    x.err = er;
    x.acc = cyc + 1;
    x.lat = sel ? 1 : 2;
    q.push_back(x);
    last_acc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_low", req_ready, 0);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      chk("pulse_width", prev_v, 0);
      if (q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = q.pop_front();
        chk("rdata", rsp_rdata, e.rd);
        chk("err", rsp_err, e.err);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
    prev_v = rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3;
    m_led[0] = 10'h000;
    m_led[1] = 10'h000;
    m_hex[0] = 8'h00;
    m_hex[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_led", led_out, 0);
    chk("rst_hex", hex_out, 0);

    // abort a pending LED write while in WAIT
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'hF2;
    req_wdata = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_led", led_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    chk("abort_led2", led_out, 0);
    chk("abort_hex", hex_out, 0);

    send(1, 8'h10, 8'h5A, 0);
    send(0, 8'h10, 8'h00, 0);
    drain();

    sw_in = 10'h2C3;
    repeat (4) @(negedge clk);
    send(0, 8'hF0, 8'h00, 0);
    send(0, 8'hF1, 8'h00, 0);
    send(1, 8'hF2, 8'hA5, 0);
    send(1, 8'hF3, 8'hFF, 0);
    drain();
    chk("led_out", led_out, 10'h3A5);
    send(1, 8'hF4, 8'h7E, 0);
    drain();
    chk("hex_out", hex_out, 8'h7E);
    send(0, 8'hF2, 8'h00, 0);
    send(0, 8'hF3, 8'h00, 0);
    send(0, 8'hF4, 8'h00, 0);

    send(1, 8'hF0, 8'h11, 0);
    send(0, 8'hF0, 8'h00, 0);
    send(0, 8'hF8, 8'h00, 0);
    send(1, 8'hFF, 8'h33, 0);

    send(1, 8'hEF, 8'h3C, 0);
    send(1, 8'h00, 8'hC5, 0);
    send(0, 8'hEF, 8'h00, 0);
    send(0, 8'h00, 8'h00, 0);
    drain();
    chk("led_keep", led_out, 10'h3A5);

    sel = 1'b1;
    @(negedge clk);
    send(1, 8'h20, 8'h11, 1);
    a0 = last_acc;
    send(1, 8'h21, 8'h22, 1);
    a1 = last_acc;
    send(0, 8'h20, 8'h00, 1);
    a2 = last_acc;
    send(0, 8'h21, 8'h00, 0);
    a3 = last_acc;
    chk("b2b_gap1", a1 - a0, 3);
    chk("b2b_gap2", a2 - a1, 3);
    chk("b2b_gap3", a3 - a2, 3);
    send(1, 8'hF4, 8'h96, 0);
    drain();
    chk("w0_hex", hex_out, 8'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
